move_scheduler: RTL
===================

# move_scheduler

Move-segment scheduler between the SPI command decoder and the stepper motion generator in the rapcore user project. It buffers queued move segments (direction, per-tick increment, duration) in a small FIFO and sequences them one at a time onto the motion datapath. It drives the `BUFFER_DTR` and `MOVE_DONE` pads and honours the `HALT` pad as an abort-and-flush.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DUR_W`, 32: duration field width, in motion ticks.
- `INC_W`, 64: signed per-tick increment width.

Ports (name, direction, width, meaning):
- `CLK` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle motion-tick strobe from the prescaler.
- `HALT` in 1: level; abort the current move and flush the FIFO.
- `wr_valid` in 1: move offered by the SPI decoder.
- `wr_ready` out 1: move accepted when `wr_valid && wr_ready`.
- `wr_dir` in 1: direction of the offered move.
- `wr_inc` in `INC_W`: increment of the offered move.
- `wr_dur` in `DUR_W`: duration of the offered move.
- `move_active` out 1: high while a move is executing.
- `cur_dir` out 1: direction of the executing move.
- `cur_inc` out `INC_W`: increment of the executing move.
- `MOVE_DONE` out 1: one-cycle pulse per completed move.
- `BUFFER_DTR` out 1: FIFO not full.
- `fifo_count` out $clog2(DEPTH)+1: entries queued, excluding the executing move.
- `halted` out 1: high in the HALTED state.

## Operation
- FSM states: IDLE, RUN, HALTED. State encoding is 2 bits.
- IDLE:
  - `fifo_count != 0` → RUN at the next edge.
  - On that edge the head entry is popped into `cur_dir`/`cur_inc`, and `remaining` is set to `wr_dur` of that entry.
- RUN:
  - On each `tick`, `remaining` decrements.
  - The move completes on the edge where `tick && remaining == 1`. A move with duration 0 completes on the first edge after load, regardless of `tick`.
  - On completion, `MOVE_DONE` pulses for the following cycle.
  - If the FIFO is non-empty at completion, the next entry loads on the same edge: back-to-back, `move_active` stays high, no gap cycle. Otherwise the FSM goes to IDLE.
- HALT (highest priority, from any state):
  - Next edge → HALTED. The FIFO is flushed (`fifo_count` becomes 0), `move_active` drops, `cur_inc` becomes 0, and no `MOVE_DONE` is issued for the aborted move.
  - HALTED stays while `HALT` is high, with `wr_ready` held 0. `HALT` low → IDLE at the next edge.
- Write path:
  - `wr_ready = !full && state != HALTED`, computed from the registered count.
  - A write and a pop in the same cycle leave the count unchanged.
  - A write is never accepted when full, even if a pop occurs in the same cycle.
- `BUFFER_DTR = (fifo_count < DEPTH)`.
- `remaining` is `DUR_W` bits and never wraps below 0. An `INC_W` value is passed through unmodified.

## Timing
- Reset values:
  - State IDLE; `fifo_count` 0; `move_active` 0; `cur_dir` 0; `cur_inc` 0.
  - `MOVE_DONE` 0; `halted` 0; `wr_ready` 1; `BUFFER_DTR` 1.
- Latency from write accepted at edge N (empty FIFO, IDLE):
  - `fifo_count` = 1 after N.
  - `move_active` = 1 and `cur_*` valid after N+1.
- A move of duration D occupies exactly D `tick` strobes. `MOVE_DONE` is high in the cycle after the D-th tick edge.
- Reset asserted mid-move forces the reset values immediately (asynchronous). No `MOVE_DONE` is issued.
- `HALT` and completion on the same edge: HALT wins, and no `MOVE_DONE` is issued.
- `HALT` and a write on the same edge: the write is accepted (`wr_ready` was 1), then flushed.

## Structure
- The shared rapcore package/defines header holds the FSM state encodings and the default widths `DUR_W` and `INC_W`, which are shared with the SPI decoder and the motion generator.
- One sub-module, `move_fifo`:
  - Synchronous FIFO with a width-`1+INC_W+DUR_W` payload, `DEPTH` entries, and wrapping pointers.
  - Provides `push`, `pop`, `flush`, `count`, `full`, `empty`.
- The scheduler FSM, the `remaining` counter and the output registers live in `move_scheduler` itself.

## Test plan
- **Single move.** Write {dir=1, inc=5, dur=3}, `tick` every 4 cycles → `move_active` high for exactly 3 ticks, `cur_inc`=5, a single `MOVE_DONE` pulse, then IDLE with `fifo_count`=0.
- **Fill and back-to-back.** Write 5 moves with dur=2 at `DEPTH`=4 before any tick:
  - `wr_ready`/`BUFFER_DTR` drop when `fifo_count`=4, after the 5th write (the first move is already popped into RUN).
  - All 5 complete with no gap in `move_active`.
  - 5 `MOVE_DONE` pulses occur.
- **Zero duration.** Write {inc=7, dur=0} → `move_active` high 1 cycle, `MOVE_DONE` the next cycle, and no tick is required.
- **HALT mid-move.** HALT mid-move with 2 moves queued → next cycle `move_active`=0, `fifo_count`=0, `halted`=1, `wr_ready`=0, and no `MOVE_DONE`. Release HALT → IDLE; a new write then executes normally.
- **Completion vs HALT.** Assert HALT on the same edge as the final tick of a move → no `MOVE_DONE`, and the FSM enters HALTED.
- **Reset mid-move.** Assert `reset` asynchronously between edges during RUN → all outputs at their reset values before the next `CLK` edge.

Source files
------------

// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the move scheduler: the FSM state encodings and the default field widths
// that the SPI decoder and the motion generator also use.
package move_scheduler_pkg;

  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefDurW  = 32;
  localparam int unsigned DefIncW  = 64;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } sched_state_e;

endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO for queued move segments. Both pointers wrap naturally because Depth is a power
// of two. Flush clears the FIFO and overrides any push or pop on the same edge.
module move_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 97
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == Depth[PtrW:0]);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem[rptr_q];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the count and the pointers decide what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/move_scheduler.sv
// Move-segment scheduler: queues moves in move_fifo and runs them one at a time, counting motion
// ticks. A completing move hands over to the next queued move on the same edge.
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned DUR_W = DefDurW,
  parameter int unsigned INC_W = DefIncW
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   HALT,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   wr_dir,
  input  logic [INC_W-1:0]       wr_inc,
  input  logic [DUR_W-1:0]       wr_dur,
  output logic                   move_active,
  output logic                   cur_dir,
  output logic [INC_W-1:0]       cur_inc,
  output logic                   MOVE_DONE,
  output logic                   BUFFER_DTR,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   halted
);

  localparam int unsigned EntryW = 1 + INC_W + DUR_W;

  sched_state_e state_q, state_d;
  logic             cur_dir_q, cur_dir_d;
  logic [INC_W-1:0] cur_inc_q, cur_inc_d;
  logic [DUR_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;

  logic              push, pop, flush, full, empty;
  logic [EntryW-1:0] head;
  logic              head_dir;
  logic [INC_W-1:0]  head_inc;
  logic [DUR_W-1:0]  head_dur;
  logic              finishing;

  move_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({wr_dir, wr_inc, wr_dur}),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign head_dir = head[EntryW-1];
  assign head_inc = head[INC_W+DUR_W-1:DUR_W];
  assign head_dur = head[DUR_W-1:0];

  assign wr_ready    = !full && (state_q != StHalted);
  assign push        = wr_valid && wr_ready;
  assign BUFFER_DTR  = !full;
  assign move_active = (state_q == StRun);
  assign halted      = (state_q == StHalted);
  assign cur_dir     = cur_dir_q;
  assign cur_inc     = cur_inc_q;
  assign MOVE_DONE   = done_q;

  // A zero-duration move finishes on the first edge after load, tick or not.
  assign finishing = (remaining_q == '0) || (tick && (remaining_q == DUR_W'(1)));

  always_comb begin
    state_d     = state_q;
    cur_dir_d   = cur_dir_q;
    cur_inc_d   = cur_inc_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    if (HALT) begin
      state_d     = StHalted;
      flush       = 1'b1;
      cur_dir_d   = 1'b0;
      cur_inc_d   = '0;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            pop         = 1'b1;
            cur_dir_d   = head_dir;
            cur_inc_d   = head_inc;
            remaining_d = head_dur;
            state_d     = StRun;
          end
        end
        StRun: begin
          if (finishing) begin
            done_d = 1'b1;
            if (!empty) begin
              pop         = 1'b1;
              cur_dir_d   = head_dir;
              cur_inc_d   = head_inc;
              remaining_d = head_dur;
            end else begin
              state_d = StIdle;
            end
          end else if (tick) begin
            remaining_d = remaining_q - DUR_W'(1);
          end
        end
        StHalted: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_dir_q   <= 1'b0;
      cur_inc_q   <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_dir_q   <= cur_dir_d;
      cur_inc_q   <= cur_inc_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

endmodule
